// File: rtl/regfile_sb.sv
// ============================================================================
// regfile_sb : 2R/1W register file with write-back bypass and busy scoreboard
// Rev 1.0    : initial release
// ============================================================================
`default_nettype none

module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ch1,
    output logic [DATA_W-1:0] data1,
    output logic              busy1,
    input  logic [ADDR_W-1:0] ch2,
    output logic [DATA_W-1:0] data2,
    output logic              busy2,
    input  logic              en3,
    input  logic [ADDR_W-1:0] ch3,
    input  logic [DATA_W-1:0] data3,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_ch,
    input  logic              flush,
    output logic [ADDR_W:0]   busy_cnt
);

    localparam int c_DEPTH    = 1 << ADDR_W;
    localparam bit c_HAS_ZERO = (ZERO_REG != 0);

    logic [DATA_W-1:0]  r_regs [c_DEPTH];
    logic [c_DEPTH-1:0] r_busy;
    logic [ADDR_W:0]    r_busy_cnt;

    logic [c_DEPTH-1:0] w_busy_nxt;
    logic [ADDR_W:0]    w_busy_pop;
    logic               w_wr_ok;
    logic [ADDR_W-1:0]  w_rd_ch   [2];
    logic [DATA_W-1:0]  w_rd_data [2];
    logic               w_rd_busy [2];

    assign w_wr_ok = en3 && !(c_HAS_ZERO && (ch3 == '0));

    assign w_rd_ch[0] = ch1;
    assign w_rd_ch[1] = ch2;

    // A same-cycle write-back both supplies the data and satisfies the hazard.
    generate
        for (genvar p = 0; p < 2; p++) begin : g_rd_port
            logic w_is_zero;
            logic w_hit;

            assign w_is_zero    = c_HAS_ZERO && (w_rd_ch[p] == '0);
            assign w_hit        = en3 && (ch3 == w_rd_ch[p]);
            assign w_rd_data[p] = w_is_zero ? '0 :
                                  w_hit     ? data3 : r_regs[w_rd_ch[p]];
            assign w_rd_busy[p] = !w_is_zero && r_busy[w_rd_ch[p]] && !w_hit;
        end
    endgenerate

    assign data1    = w_rd_data[0];
    assign busy1    = w_rd_busy[0];
    assign data2    = w_rd_data[1];
    assign busy2    = w_rd_busy[1];
    assign busy_cnt = r_busy_cnt;

    // Issue outranks write-back: the newly issued producer is still pending.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int i = 0; i < c_DEPTH; i++) begin
            if (flush) begin
                w_busy_nxt[i] = 1'b0;
            end else if (iss_en && (iss_ch == ADDR_W'(i))) begin
                w_busy_nxt[i] = 1'b1;
            end else if (en3 && (ch3 == ADDR_W'(i))) begin
                w_busy_nxt[i] = 1'b0;
            end
        end
        if (c_HAS_ZERO) begin
            w_busy_nxt[0] = 1'b0;
        end
    end

    always_comb begin
        w_busy_pop = '0;
        for (int i = 0; i < c_DEPTH; i++) begin
            w_busy_pop = w_busy_pop + {{ADDR_W{1'b0}}, w_busy_nxt[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy     <= '0;
            r_busy_cnt <= '0;
            for (int i = 0; i < c_DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_busy     <= w_busy_nxt;
            r_busy_cnt <= w_busy_pop;
            if (w_wr_ok) begin
                r_regs[ch3] <= data3;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_regfile_sb.sv
// ============================================================================
// tb_regfile_sb : directed vector bench for regfile_sb (ZERO_REG=1 and =0)
// Rev 1.0       : initial release
// ============================================================================
`default_nettype none

module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  ch1 = '0, ch2 = '0, ch3 = '0, iss_ch = '0;
    logic        en3 = 1'b0, iss_en = 1'b0, flush = 1'b0;
    logic [31:0] data3 = '0;

    logic [31:0] data1, data2, z_data1, z_data2;
    logic        busy1, busy2, z_busy1, z_busy2;
    logic [5:0]  busy_cnt, z_busy_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .ch1(ch1), .data1(data1), .busy1(busy1),
        .ch2(ch2), .data2(data2), .busy2(busy2),
        .en3(en3), .ch3(ch3), .data3(data3),
        .iss_en(iss_en), .iss_ch(iss_ch), .flush(flush),
        .busy_cnt(busy_cnt)
    );

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) u_dut_nz (
        .clk(clk), .rst_n(rst_n),
        .ch1(ch1), .data1(z_data1), .busy1(z_busy1),
        .ch2(ch2), .data2(z_data2), .busy2(z_busy2),
        .en3(en3), .ch3(ch3), .data3(data3),
        .iss_en(iss_en), .iss_ch(iss_ch), .flush(flush),
        .busy_cnt(z_busy_cnt)
    );

    typedef struct {
        logic        rst_n;
        logic        en3;
        logic [4:0]  ch3;
        logic [31:0] data3;
        logic        iss_en;
        logic [4:0]  iss_ch;
        logic        flush;
        logic [4:0]  ch1;
        logic [4:0]  ch2;
        logic        chk_comb;
        logic [31:0] d1;
        logic        b1;
        logic [31:0] d2;
        logic        b2;
        logic [5:0]  cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic r, input logic e3, input logic [4:0] c3, input logic [31:0] d3,
        input logic ie, input logic [4:0] ic, input logic fl,
        input logic [4:0] c1, input logic [4:0] c2, input logic cc,
        input logic [31:0] x1, input logic xb1, input logic [31:0] x2, input logic xb2,
        input logic [5:0] xc);
        vec_t v;
        v.rst_n = r;  v.en3 = e3; v.ch3 = c3; v.data3 = d3;
        v.iss_en = ie; v.iss_ch = ic; v.flush = fl;
        v.ch1 = c1; v.ch2 = c2; v.chk_comb = cc;
        v.d1 = x1; v.b1 = xb1; v.d2 = x2; v.b2 = xb2; v.cnt = xc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        rst_n = 1'b1; en3 = 1'b0; ch3 = '0; data3 = '0;
        iss_en = 1'b0; iss_ch = '0; flush = 1'b0;
    endtask

    initial begin
        //           rst en3 ch3 data3         iss ich fl ch1 ch2 cc d1            b1 d2            b2 cnt
        vecs.push_back(mk(0, 0,  0, 32'h0,        0,  0, 0,  5,  7, 0, 32'h0,        0, 32'h0,        0, 0));
        vecs.push_back(mk(1, 1,  5, 32'hDEADBEEF, 0,  0, 0,  5,  7, 1, 32'hDEADBEEF, 0, 32'h0,        0, 0));
        vecs.push_back(mk(1, 0,  0, 32'h0,        0,  0, 0,  5,  7, 1, 32'hDEADBEEF, 0, 32'h0,        0, 0));
        vecs.push_back(mk(1, 1,  0, 32'h1234,     1,  0, 0,  0,  5, 1, 32'h0,        0, 32'hDEADBEEF, 0, 0));
        vecs.push_back(mk(1, 0,  0, 32'h0,        0,  0, 0,  0,  0, 1, 32'h0,        0, 32'h0,        0, 0));
        vecs.push_back(mk(1, 0,  0, 32'h0,        0,  0, 0,  9,  9, 1, 32'h0,        0, 32'h0,        0, 0));
        vecs.push_back(mk(1, 1,  9, 32'hA5A5A5A5, 0,  0, 0,  9,  9, 1, 32'hA5A5A5A5, 0, 32'hA5A5A5A5, 0, 0));
        vecs.push_back(mk(1, 0,  0, 32'h0,        0,  0, 0,  9,  9, 1, 32'hA5A5A5A5, 0, 32'hA5A5A5A5, 0, 0));
        vecs.push_back(mk(1, 0,  0, 32'h0,        1,  3, 0,  3,  9, 1, 32'h0,        0, 32'hA5A5A5A5, 0, 1));
        vecs.push_back(mk(1, 0,  0, 32'h0,        0,  0, 0,  3,  3, 1, 32'h0,        1, 32'h0,        1, 1));
        vecs.push_back(mk(1, 1,  3, 32'h33333333, 0,  0, 0,  3,  3, 1, 32'h33333333, 0, 32'h33333333, 0, 0));
        vecs.push_back(mk(1, 1,  3, 32'h44444444, 1,  3, 0,  3,  9, 1, 32'h44444444, 0, 32'hA5A5A5A5, 0, 1));
        vecs.push_back(mk(1, 0,  0, 32'h0,        0,  0, 0,  3,  3, 1, 32'h44444444, 1, 32'h44444444, 1, 1));
        vecs.push_back(mk(1, 1,  3, 32'h55,       0,  0, 0,  3,  0, 1, 32'h55,       0, 32'h0,        0, 0));
        vecs.push_back(mk(1, 0,  0, 32'h0,        1,  1, 0,  1,  2, 1, 32'h0,        0, 32'h0,        0, 1));
        vecs.push_back(mk(1, 0,  0, 32'h0,        1,  2, 0,  1,  2, 1, 32'h0,        1, 32'h0,        0, 2));
        vecs.push_back(mk(1, 0,  0, 32'h0,        1,  4, 0,  2,  4, 1, 32'h0,        1, 32'h0,        0, 3));
        vecs.push_back(mk(1, 1,  2, 32'h22222222, 1,  6, 1,  2,  4, 1, 32'h22222222, 0, 32'h0,        1, 0));
        vecs.push_back(mk(1, 0,  0, 32'h0,        0,  0, 0,  2,  6, 1, 32'h22222222, 0, 32'h0,        0, 0));
        vecs.push_back(mk(1, 0,  0, 32'h0,        0,  0, 0,  1,  4, 1, 32'h0,        0, 32'h0,        0, 0));
        vecs.push_back(mk(1, 1, 10, 32'h55,       1, 11, 0, 10, 11, 1, 32'h55,       0, 32'h0,        0, 1));
        vecs.push_back(mk(1, 0,  0, 32'h0,        1, 12, 0, 10, 11, 1, 32'h55,       0, 32'h0,        1, 2));
        vecs.push_back(mk(1, 0,  0, 32'h0,        1, 13, 0, 12, 13, 1, 32'h0,        1, 32'h0,        0, 3));
        vecs.push_back(mk(1, 0,  0, 32'h0,        1, 14, 0, 13, 14, 1, 32'h0,        1, 32'h0,        0, 4));
        vecs.push_back(mk(0, 1, 10, 32'h99,       1, 15, 1, 10, 14, 1, 32'h99,       0, 32'h0,        1, 0));
        vecs.push_back(mk(1, 0,  0, 32'h0,        0,  0, 0, 10, 14, 1, 32'h0,        0, 32'h0,        0, 0));
        vecs.push_back(mk(1, 0,  0, 32'h0,        0,  0, 0, 15, 11, 1, 32'h0,        0, 32'h0,        0, 0));
        vecs.push_back(mk(1, 1, 31, 32'hFFFFFFFF, 1, 31, 0, 31, 31, 1, 32'hFFFFFFFF, 0, 32'hFFFFFFFF, 0, 1));
        vecs.push_back(mk(1, 0,  0, 32'h0,        0,  0, 0, 31, 31, 1, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 1, 1));
        vecs.push_back(mk(1, 1, 31, 32'h1,        0,  0, 0, 31, 31, 1, 32'h1,        0, 32'h1,        0, 0));

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            rst_n  = vecs[i].rst_n;  en3    = vecs[i].en3;    ch3   = vecs[i].ch3;
            data3  = vecs[i].data3;  iss_en = vecs[i].iss_en; iss_ch = vecs[i].iss_ch;
            flush  = vecs[i].flush;  ch1    = vecs[i].ch1;    ch2   = vecs[i].ch2;
            #2;
            if (vecs[i].chk_comb) begin
                chk($sformatf("v%0d data1", i), data1, vecs[i].d1);
                chk($sformatf("v%0d busy1", i), {31'b0, busy1}, {31'b0, vecs[i].b1});
                chk($sformatf("v%0d data2", i), data2, vecs[i].d2);
                chk($sformatf("v%0d busy2", i), {31'b0, busy2}, {31'b0, vecs[i].b2});
            end
            @(posedge clk);
            #1;
            chk($sformatf("v%0d busy_cnt", i), {26'b0, busy_cnt}, {26'b0, vecs[i].cnt});
        end

        // Register 0 as an ordinary register vs. hardwired zero, same stimulus.
        idle();
        en3 = 1'b1; ch3 = 5'd0; data3 = 32'h1234; iss_en = 1'b1; iss_ch = 5'd0;
        ch1 = 5'd0; ch2 = 5'd0;
        #2;
        chk("zr1 bypass data1", data1, 32'h0);
        chk("zr1 bypass busy1", {31'b0, busy1}, 32'h0);
        chk("zr0 bypass data1", z_data1, 32'h1234);
        @(posedge clk);
        #1;
        idle();
        #2;
        chk("zr1 r0 data1", data1, 32'h0);
        chk("zr1 r0 busy1", {31'b0, busy1}, 32'h0);
        chk("zr1 busy_cnt", {26'b0, busy_cnt}, 32'h0);
        chk("zr0 r0 data1", z_data1, 32'h1234);
        chk("zr0 r0 busy1", {31'b0, z_busy1}, 32'h1);
        chk("zr0 busy_cnt", {26'b0, z_busy_cnt}, 32'h1);
        en3 = 1'b1; ch3 = 5'd0; data3 = 32'h77;
        #2;
        chk("zr0 wb busy1", {31'b0, z_busy1}, 32'h0);
        chk("zr0 wb data1", z_data1, 32'h77);
        @(posedge clk);
        #1;
        idle();
        #2;
        chk("zr0 wb busy_cnt", {26'b0, z_busy_cnt}, 32'h0);
        chk("zr0 wb stored", z_data1, 32'h77);
        chk("zr1 wb dropped", data1, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
